// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, shift-register control
// encodings and the oversampling ratio used by both tx and rx controllers.
package uart_pkg;

    // Baud generator produces this many s_tick strobes per bit period.
    localparam int OVERSAMPLE = 16;

    // Transmit FSM states; the numeric values are what fsm_state reports.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Control encodings understood by shift_reg.
    typedef enum logic [1:0] {
        SR_LOAD  = 2'b00,
        SR_RIGHT = 2'b01,
        SR_LEFT  = 2'b10,
        SR_HOLD  = 2'b11
    } sr_ctrl_t;

endpackage

// File: rtl/shift_reg.sv
// Generic N-bit shift register with parallel load, right/left shift and hold.
// Only changes when en is high; ctrl selects the operation.
module shift_reg
    import uart_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] d,
    input  logic         si,
    output logic [N-1:0] q
);

    // Register update: load, shift in si from the selected end, or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            case (ctrl)
                SR_LOAD:  q <= d;
                SR_RIGHT: q <= {si, q[N-1:1]};
                SR_LEFT:  q <= {q[N-2:0], si};
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a D_BIT word as start bit, data bits
// (LSB first), optional even parity and a stop period of SB_TICK ticks.
// Timing comes from a 16x oversampling s_tick strobe.
//
// Handshake: tx_start is a request that is taken only while the FSM is in
// IDLE; the cycle it is seen there is the acceptance cycle and din is
// captured on that edge. tx_busy is high from the cycle after acceptance
// through the tx_done_tick cycle. There is no backpressure and no queueing:
// a request outside IDLE is dropped.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int D_BIT   = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_EN  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tick,
    input  logic             tx_start,
    input  logic [D_BIT-1:0] din,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done_tick,
    output logic [2:0]       fsm_state
);

    // Tick counter must reach the larger of the bit period and stop period.
    localparam int S_MAX = (SB_TICK - 1 > OVERSAMPLE - 1) ? SB_TICK - 1 : OVERSAMPLE - 1;
    localparam int S_W   = $clog2(S_MAX + 1);
    localparam int N_W   = (D_BIT > 1) ? $clog2(D_BIT) : 1;

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(D_BIT - 1);

    tx_state_t      state, state_n;
    logic [S_W-1:0] s, s_n;
    logic [N_W-1:0] n, n_n;
    logic           par, par_n;
    logic           tx_n, busy_n, done_n;
    logic           sr_en;
    sr_ctrl_t       sr_ctrl;
    logic [D_BIT-1:0] sr_q;
    logic           sr_unused;

    shift_reg #(.N(D_BIT)) u_shift_reg (
        .clk  (clk),
        .rst  (rst),
        .en   (sr_en),
        .ctrl (sr_ctrl),
        .d    (din),
        .si   (1'b0),
        .q    (sr_q)
    );

    // Only the two low bits feed the line; the rest is shift storage.
    assign sr_unused = ^sr_q[D_BIT-1:2];
    assign fsm_state = state;

    // State, counters and line outputs; reset drops the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            s            <= '0;
            n            <= '0;
            par          <= 1'b0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            par          <= par_n;
            tx           <= tx_n;
            tx_busy      <= busy_n;
            tx_done_tick <= done_n;
        end
    end

    // Next-state, counter, shift control and registered-line values.
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        par_n   = par;
        done_n  = 1'b0;
        sr_en   = 1'b0;
        sr_ctrl = SR_HOLD;
        tx_n    = 1'b1;

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    sr_en   = 1'b1;
                    sr_ctrl = SR_LOAD;
                    s_n     = '0;
                    par_n   = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s == S_BIT_LAST) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = ST_DATA;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s == S_BIT_LAST) begin
                        sr_en   = 1'b1;
                        sr_ctrl = SR_RIGHT;
                        par_n   = par ^ sr_q[0];
                        s_n     = '0;
                        if (n == N_LAST) begin
                            state_n = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s == S_BIT_LAST) begin
                        s_n     = '0;
                        state_n = ST_STOP;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s == S_STOP_LAST) begin
                        s_n     = '0;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // The line is registered, so it is derived from the state being
        // entered; in DATA it follows the shift register after this edge.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = (sr_en && sr_ctrl == SR_RIGHT) ? sr_q[1] : sr_q[0];
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase

        // Busy covers the whole frame including the done-pulse cycle.
        busy_n = (state_n != ST_IDLE) || done_n;
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: three configurations share stimulus
// (8N1, 8E1 with parity, 8N2 with a 32-tick stop period).
module tb_uart_tx_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s_tick;
    logic [7:0] din;
    logic       start0, start1, start2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] st0, st1, st2;

    int n_checks = 0;
    int n_bad    = 0;

    // tick generator: mode 0 = none, 1 = every tick_per clks, 2 = random 1..20
    int tick_mode = 0;
    int tick_per  = 4;
    int gap       = 1;

    logic [11:0] exp_q[$];

    uart_tx_ctrl #(.D_BIT(8), .SB_TICK(16), .PAR_EN(0)) dut_base (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start0), .din(din),
        .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0), .fsm_state(st0));

    uart_tx_ctrl #(.D_BIT(8), .SB_TICK(16), .PAR_EN(1)) dut_par (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start1), .din(din),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1), .fsm_state(st1));

    uart_tx_ctrl #(.D_BIT(8), .SB_TICK(32), .PAR_EN(0)) dut_sb2 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start2), .din(din),
        .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2), .fsm_state(st2));

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            0: return tx0;
            1: return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [2:0] state_of(input int sel);
        case (sel)
            0: return st0;
            1: return st1;
            default: return st2;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    // Advance one clock; outputs are stable #1 after the edge, then the
    // tick for the next edge is chosen.
    task automatic clk_step();
        @(posedge clk);
        #1;
        if (tick_mode == 0) begin
            s_tick = 1'b0;
        end else if (gap <= 1) begin
            s_tick = 1'b1;
            gap = (tick_mode == 2) ? int'($urandom_range(1, 20)) : tick_per;
        end else begin
            s_tick = 1'b0;
            gap--;
        end
    endtask

    // ---------------- driver / monitor ----------------
    // Sends one frame on instance sel, samples the line mid-bit (tick 8 of
    // each 16), and checks against the front of exp_q. exp_dur < 0 skips the
    // length check; hold keeps tx_start high and din unchanged after acceptance.
    task automatic run_frame(input int sel, input logic [7:0] data, input int nbits,
                             input int exp_dur, input bit hold, input bit align);
        logic [11:0] got;
        logic [11:0] exp_bits;
        logic [11:0] mask;
        int tidx;
        int dur;
        bit seen;
        bit busy_drop;
        din = data;
        set_start(sel, 1'b1);
        if (align) begin
            s_tick = 1'b1;
            gap = tick_per;
        end
        clk_step();
        if (!hold) begin
            set_start(sel, 1'b0);
            din = ~data;
        end
        check("line_low_after_accept", tx_of(sel), 1'b0);
        check("busy_after_accept", busy_of(sel), 1'b1);
        got = '0;
        tidx = 0;
        dur = 0;
        seen = 1'b0;
        busy_drop = 1'b0;
        while (!seen && dur < 8000) begin
            if (s_tick) begin
                if ((tidx % 16) == 8 && (tidx / 16) < nbits) got[tidx / 16] = tx_of(sel);
                tidx++;
            end
            clk_step();
            dur++;
            if (done_of(sel)) seen = 1'b1;
            else if (!busy_of(sel)) busy_drop = 1'b1;
        end
        check("done_pulse_seen", seen, 1'b1);
        check("busy_held_in_frame", busy_drop, 1'b0);
        exp_bits = exp_q.pop_front();
        mask = 12'((1 << nbits) - 1);
        check("frame_bits", got & mask, exp_bits & mask);
        if (exp_dur >= 0) check("frame_clks", dur, exp_dur);
        check("busy_in_done_cycle", busy_of(sel), 1'b1);
    endtask

    // One cycle after a frame with no new request: everything back at rest.
    task automatic check_idle(input int sel);
        clk_step();
        check("idle_tx", tx_of(sel), 1'b1);
        check("idle_busy", busy_of(sel), 1'b0);
        check("idle_done", done_of(sel), 1'b0);
        check("idle_state", state_of(sel), 3'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tidx;
        bit done_in_rst;
        rst = 1'b0;
        s_tick = 1'b0;
        din = 8'h00;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;

        repeat (3) clk_step();
        check("rst_tx", {tx2, tx1, tx0}, 3'b111);
        check("rst_busy", {busy2, busy1, busy0}, 3'b000);
        check("rst_done", {done2, done1, done0}, 3'b000);
        check("rst_state", {st2, st1, st0}, 9'd0);
        rst = 1'b1;
        clk_step();
        check("rst_released_idle", {tx0, busy0, st0}, 5'b10000);

        // 8N1 0x55, ticks every 4 clks aligned so the frame is 640 clks
        tick_mode = 1;
        tick_per = 4;
        exp_q.push_back(12'h2AA);
        run_frame(0, 8'h55, 10, 640, 1'b0, 1'b1);
        check_idle(0);

        // 8E1 0x07: three ones -> parity 1; 11 bit periods = 704 clks
        exp_q.push_back(12'h60E);
        run_frame(1, 8'h07, 11, 704, 1'b0, 1'b1);
        check_idle(1);

        // 32-tick stop, 0xFF, tick every clock: 9*16 + 32 = 176 ticks
        tick_per = 1;
        exp_q.push_back(12'h3FE);
        run_frame(2, 8'hFF, 10, 176, 1'b0, 1'b1);
        check_idle(2);

        // tx_start held high: one frame, then next starts right after done
        tick_per = 4;
        exp_q.push_back(12'h278);
        run_frame(0, 8'h3C, 10, -1, 1'b1, 1'b0);
        exp_q.push_back(12'h278);
        run_frame(0, 8'h3C, 10, -1, 1'b0, 1'b0);
        check_idle(0);

        // continuous tick: 160 ticks, one per clock
        tick_per = 1;
        exp_q.push_back(12'h2AA);
        run_frame(0, 8'h55, 10, 160, 1'b0, 1'b1);
        check_idle(0);

        // random tick gaps, 0x81
        tick_mode = 2;
        gap = 1;
        exp_q.push_back(12'h302);
        run_frame(0, 8'h81, 10, -1, 1'b0, 1'b0);
        check_idle(0);

        // reset in the middle of the data bits of 0xA5
        tick_mode = 1;
        tick_per = 4;
        din = 8'hA5;
        start0 = 1'b1;
        clk_step();
        start0 = 1'b0;
        tidx = 0;
        for (int i = 0; i < 400 && tidx < 40; i++) begin
            if (s_tick) tidx++;
            clk_step();
        end
        check("mid_frame_state_data", st0, 3'd2);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_tx", tx0, 1'b1);
        check("async_rst_busy", busy0, 1'b0);
        check("async_rst_state", st0, 3'd0);
        done_in_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clk_step();
            if (done0) done_in_rst = 1'b1;
        end
        check("no_done_on_abort", done_in_rst, 1'b0);
        rst = 1'b1;
        clk_step();
        if (done0) done_in_rst = 1'b1;
        check("no_done_after_release", done_in_rst, 1'b0);
        exp_q.push_back(12'h34A);
        run_frame(0, 8'hA5, 10, 640, 1'b0, 1'b1);
        check_idle(0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
